jtag_cmd_stream_decoder: RTL and testbench
==========================================

JTAG_CMD_STREAM_DECODER -- requirements
Module: jtag_cmd_stream_decoder

Interface
REQ-001 SHALL have parameter ARG_BYTES, default 2, meaning bytes per data word (1..4, little-endian).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning data-word FIFO depth (power of 2, >=2).
REQ-003 SHALL have parameter INSTR_W, default 7, meaning instruction width.
REQ-004 SHALL have parameters ESC_CHAR=8'hFE, ESC_IDLE=8'h00, ESC_ACK=8'h01 and ESC_LIT=8'hFD, meaning the escape byte and its escape sub-codes.
REQ-005 SHALL have parameters INSTR_IDLE=0, INSTR_ACK=7'h7E and INSTR_ERROR=7'h7F, meaning the emitted instruction codes.
REQ-006 SHALL have iCLK, input, 1 bit: the single clock; all logic rises on posedge iCLK.
REQ-007 SHALL have iRST_N, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have iBYTE, input, 8 bits: the raw host byte stream.
REQ-009 SHALL have iBYTE_VALID, input, 1 bit, and oBYTE_READY, output, 1 bit; a byte is accepted on a cycle when both are high.
REQ-010 SHALL have iIDLE_TO_TAKE_COMMAND, input, 1 bit: high selects command mode, low selects data mode.
REQ-011 SHALL have oINSTR, output, INSTR_W bits; oINSTR_VALID, output, 1 bit; and iINSTR_ACK, input, 1 bit.
REQ-012 SHALL have oDATA, output, 8*ARG_BYTES bits; oDATA_VALID, output, 1 bit; and iDATA_ACK, input, 1 bit (FIFO head, show-ahead).
REQ-013 SHALL have oFIFO_LEVEL, output, log2(FIFO_DEPTH)+1 bits: current word count.
REQ-014 SHALL have oOVERFLOW, output, 1 bit (sticky), and iCLR_OVERFLOW, input, 1 bit.

Function
REQ-015 SHALL implement a two-state FSM: NORMAL and ESCAPED.
REQ-016 In NORMAL, an accepted ESC_CHAR SHALL move the FSM to ESCAPED and produce no other effect.
REQ-017 In ESCAPED, any accepted byte SHALL return the FSM to NORMAL.
REQ-018 In ESCAPED, ESC_IDLE SHALL post INSTR_IDLE and clear the partial word.
REQ-019 In ESCAPED, ESC_ACK SHALL post INSTR_ACK.
REQ-020 In ESCAPED, ESC_LIT SHALL be treated as data byte 8'hFE.
REQ-021 In ESCAPED, any other byte SHALL post INSTR_ERROR and clear the partial word.
REQ-022 Escape handling SHALL be the same in both modes.
REQ-023 In NORMAL command mode, an accepted non-escape byte SHALL post instruction iBYTE[INSTR_W-1:0] and clear the partial word.
REQ-024 A data byte SHALL be a NORMAL-state data-mode non-escape byte, or an ESC_LIT in either mode.
REQ-025 Data bytes SHALL be assembled into the byte lane given by the assembly counter (0..ARG_BYTES-1); the counter increments per data byte.
REQ-026 On the final byte, the completed word SHALL be pushed into the FIFO on the same edge, and the counter SHALL wrap to 0.
REQ-027 A posted instruction SHALL be visible on oINSTR/oINSTR_VALID the cycle after acceptance (1-cycle latency).
REQ-028 iINSTR_ACK while oINSTR_VALID is high SHALL clear oINSTR_VALID on the next edge.
REQ-029 A new post on the same edge as an ack SHALL win: oINSTR_VALID stays 1 and oOVERFLOW is not set.
REQ-030 A new post while oINSTR_VALID=1 with no ack SHALL overwrite oINSTR and set oOVERFLOW.
REQ-031 A pushed word SHALL appear at the FIFO head with oDATA_VALID=1 the cycle after the push edge when the FIFO was empty.
REQ-032 iDATA_ACK with oDATA_VALID=1 SHALL pop one word; iDATA_ACK with oDATA_VALID=0 SHALL be ignored.
REQ-033 A simultaneous push and pop SHALL leave the level unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 oBYTE_READY SHALL equal (level < FIFO_DEPTH) AND iRST_N; a completed word is therefore never dropped.
REQ-035 Bytes presented while oBYTE_READY=0 SHALL NOT be consumed.
REQ-036 oOVERFLOW SHALL clear on iCLR_OVERFLOW unless a new overflow event occurs in the same cycle, in which case set wins.
REQ-037 A change of iIDLE_TO_TAKE_COMMAND SHALL NOT clear the partial word; only REQ-018, REQ-021 and REQ-023 clear it.

Reset
REQ-038 On a posedge with iRST_N=0: FSM=NORMAL, counter=0, FIFO empty, partial word=0.
REQ-039 During reset, outputs SHALL be oINSTR=0, oINSTR_VALID=0, oDATA=0, oDATA_VALID=0, oFIFO_LEVEL=0, oOVERFLOW=0, oBYTE_READY=0.
REQ-040 Reset asserted mid-word or mid-escape SHALL discard all state; the first byte after reset is decoded as fresh.

Verification (ARG_BYTES=2, FIFO_DEPTH=4)
REQ-041 Command mode: byte 8'h05 -> next cycle oINSTR=7'h05 and oINSTR_VALID=1; ack -> oINSTR_VALID=0.
REQ-042 Data mode: bytes 34,12 -> oDATA=16'h1234; bytes FE,FD,AB -> oDATA=16'hABFE.
REQ-043 Data mode: 10 bytes with no data ack -> oFIFO_LEVEL=4 and oBYTE_READY=0 after the 8th byte; one ack -> ready=1 and the 9th byte accepted.
REQ-044 Bytes 11,FE,00 -> oINSTR=INSTR_IDLE; then bytes 22,33 -> oDATA=16'h3322 (the 11 is discarded).
REQ-045 Bytes FE,55 -> INSTR_ERROR; two un-acked instructions -> oOVERFLOW=1; iCLR_OVERFLOW -> oOVERFLOW=0.
REQ-046 iRST_N=0 between bytes 1 and 2 of a word -> all outputs 0; the next two bytes form a full word.

Source files
------------

// File: rtl/jtag_cmd_stream_decoder_if.sv
// Host-side byte stream, instruction and data-word handshakes of the decoder.
interface jtag_cmd_stream_decoder_if #(
  parameter int unsigned ARG_BYTES  = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INSTR_W    = 7
);
  logic [7:0]                    iBYTE;
  logic                          iBYTE_VALID;
  logic                          oBYTE_READY;
  logic                          iIDLE_TO_TAKE_COMMAND;
  logic [INSTR_W-1:0]            oINSTR;
  logic                          oINSTR_VALID;
  logic                          iINSTR_ACK;
  logic [8*ARG_BYTES-1:0]        oDATA;
  logic                          oDATA_VALID;
  logic                          iDATA_ACK;
  logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL;
  logic                          oOVERFLOW;
  logic                          iCLR_OVERFLOW;

  // Host / testbench side.
  modport master (
    output iBYTE, iBYTE_VALID, iIDLE_TO_TAKE_COMMAND, iINSTR_ACK, iDATA_ACK, iCLR_OVERFLOW,
    input  oBYTE_READY, oINSTR, oINSTR_VALID, oDATA, oDATA_VALID, oFIFO_LEVEL, oOVERFLOW
  );

  // Decoder side.
  modport slave (
    input  iBYTE, iBYTE_VALID, iIDLE_TO_TAKE_COMMAND, iINSTR_ACK, iDATA_ACK, iCLR_OVERFLOW,
    output oBYTE_READY, oINSTR, oINSTR_VALID, oDATA, oDATA_VALID, oFIFO_LEVEL, oOVERFLOW
  );
endinterface

// File: rtl/jtag_cmd_stream_decoder.sv
// Decodes an escaped host byte stream into instructions (single holding
// register with sticky overflow) and little-endian data words (show-ahead FIFO).
module jtag_cmd_stream_decoder #(
  parameter int unsigned        ARG_BYTES   = 2,
  parameter int unsigned        FIFO_DEPTH  = 4,
  parameter int unsigned        INSTR_W     = 7,
  parameter logic [7:0]         ESC_CHAR    = 8'hFE,
  parameter logic [7:0]         ESC_IDLE    = 8'h00,
  parameter logic [7:0]         ESC_ACK     = 8'h01,
  parameter logic [7:0]         ESC_LIT     = 8'hFD,
  parameter logic [INSTR_W-1:0] INSTR_IDLE  = '0,
  parameter logic [INSTR_W-1:0] INSTR_ACK   = 7'h7E,
  parameter logic [INSTR_W-1:0] INSTR_ERROR = 7'h7F
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  jtag_cmd_stream_decoder_if.slave  bus
);

  localparam int unsigned WORD_W = 8 * ARG_BYTES;
  localparam int unsigned CNT_W  = (ARG_BYTES > 1) ? $clog2(ARG_BYTES) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(ARG_BYTES - 1);
  localparam logic [PTR_W:0]   DEPTH_L   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_NORMAL, ST_ESCAPED} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                ovf_q, ovf_d;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      level_q, level_d;

  logic                byte_ready;
  logic                accept;
  logic                post;
  logic [INSTR_W-1:0]  post_code;
  logic                data_byte;
  logic [7:0]          data_val;
  logic                clr_word;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic                pop;
  logic                ovf_set;

  assign byte_ready = (level_q < DEPTH_L) && iRST_N;
  assign accept     = bus.iBYTE_VALID && byte_ready;
  assign pop        = bus.iDATA_ACK && (level_q != '0);

  // Escape FSM: classify each accepted byte as instruction post, data byte or escape prefix.
  always_comb begin
    state_d   = state_q;
    post      = 1'b0;
    post_code = '0;
    data_byte = 1'b0;
    data_val  = '0;
    clr_word  = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (bus.iBYTE == ESC_CHAR) begin
            state_d = ST_ESCAPED;
          end else if (bus.iIDLE_TO_TAKE_COMMAND) begin
            post      = 1'b1;
            post_code = INSTR_W'(bus.iBYTE);
            clr_word  = 1'b1;
          end else begin
            data_byte = 1'b1;
            data_val  = bus.iBYTE;
          end
        end
        ST_ESCAPED: begin
          state_d = ST_NORMAL;
          if (bus.iBYTE == ESC_IDLE) begin
            post      = 1'b1;
            post_code = INSTR_IDLE;
            clr_word  = 1'b1;
          end else if (bus.iBYTE == ESC_ACK) begin
            post      = 1'b1;
            post_code = INSTR_ACK;
          end else if (bus.iBYTE == ESC_LIT) begin
            data_byte = 1'b1;
            data_val  = ESC_CHAR;
          end else begin
            post      = 1'b1;
            post_code = INSTR_ERROR;
            clr_word  = 1'b1;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  // Word assembly: drop data byte into its lane, push the word on the last lane.
  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = '0;
    if (clr_word) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (data_byte) begin
      for (int unsigned i = 0; i < ARG_BYTES; i++) begin
        if (cnt_q == CNT_W'(i)) word_d[i*8 +: 8] = data_val;
      end
      if (cnt_q == LAST_LANE) begin
        push      = 1'b1;
        push_word = word_d;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Instruction holding register; a new post beats a same-cycle ack.
  always_comb begin
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    ovf_set       = 1'b0;
    if (post) begin
      instr_d       = post_code;
      instr_valid_d = 1'b1;
      ovf_set       = instr_valid_q && !bus.iINSTR_ACK;
    end else if (bus.iINSTR_ACK && instr_valid_q) begin
      instr_valid_d = 1'b0;
    end
    ovf_d = ovf_q;
    if (ovf_set)                 ovf_d = 1'b1;
    else if (bus.iCLR_OVERFLOW)  ovf_d = 1'b0;
  end

  // Data FIFO pointers, storage and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q       <= ST_NORMAL;
      cnt_q         <= '0;
      word_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      ovf_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      ovf_q         <= ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.oBYTE_READY  = byte_ready;
  assign bus.oINSTR       = instr_q;
  assign bus.oINSTR_VALID = instr_valid_q;
  assign bus.oDATA_VALID  = (level_q != '0);
  assign bus.oDATA        = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.oFIFO_LEVEL  = level_q;
  assign bus.oOVERFLOW    = ovf_q;

endmodule

// File: tb/tb_jtag_cmd_stream_decoder.sv
// Directed bench for jtag_cmd_stream_decoder (ARG_BYTES=2, FIFO_DEPTH=4).
module tb_jtag_cmd_stream_decoder;
  logic iCLK = 1'b0;
  logic iRST_N;
  int   tests = 0;
  int   fails = 0;

  always #5 iCLK = ~iCLK;

  jtag_cmd_stream_decoder_if #(.ARG_BYTES(2), .FIFO_DEPTH(4), .INSTR_W(7)) bus ();

  jtag_cmd_stream_decoder #(.ARG_BYTES(2), .FIFO_DEPTH(4), .INSTR_W(7)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one clock edge; sampling point is #1 after it.
  task automatic put(input logic [7:0] b, input logic ack = 1'b0);
    @(negedge iCLK);
    bus.iBYTE       = b;
    bus.iBYTE_VALID = 1'b1;
    bus.iINSTR_ACK  = ack;
    @(posedge iCLK);
    #1;
    bus.iBYTE_VALID = 1'b0;
    bus.iINSTR_ACK  = 1'b0;
  endtask

  task automatic pulse_iack();
    @(negedge iCLK); bus.iINSTR_ACK = 1'b1;
    @(posedge iCLK); #1; bus.iINSTR_ACK = 1'b0;
  endtask

  task automatic pulse_dack();
    @(negedge iCLK); bus.iDATA_ACK = 1'b1;
    @(posedge iCLK); #1; bus.iDATA_ACK = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_instr"},  32'(bus.oINSTR), 32'h0);
    check({pfx, "_ivalid"}, 32'(bus.oINSTR_VALID), 32'h0);
    check({pfx, "_data"},   32'(bus.oDATA), 32'h0);
    check({pfx, "_dvalid"}, 32'(bus.oDATA_VALID), 32'h0);
    check({pfx, "_level"},  32'(bus.oFIFO_LEVEL), 32'h0);
    check({pfx, "_ovf"},    32'(bus.oOVERFLOW), 32'h0);
    check({pfx, "_ready"},  32'(bus.oBYTE_READY), 32'h0);
  endtask

  initial begin
    iRST_N                    = 1'b0;
    bus.iBYTE                 = 8'h00;
    bus.iBYTE_VALID           = 1'b0;
    bus.iIDLE_TO_TAKE_COMMAND = 1'b1;
    bus.iINSTR_ACK            = 1'b0;
    bus.iDATA_ACK             = 1'b0;
    bus.iCLR_OVERFLOW         = 1'b0;

    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    check_reset_outputs("rst");
    @(negedge iCLK); iRST_N = 1'b1;
    #1 check("ready_after_rst", 32'(bus.oBYTE_READY), 32'h1);

    // Command mode: plain byte posts an instruction, ack clears it
    put(8'h05);
    check("cmd_instr",  32'(bus.oINSTR), 32'h05);
    check("cmd_ivalid", 32'(bus.oINSTR_VALID), 32'h1);
    pulse_iack();
    check("cmd_acked",  32'(bus.oINSTR_VALID), 32'h0);

    // Data mode: two bytes form a little-endian word
    bus.iIDLE_TO_TAKE_COMMAND = 1'b0;
    put(8'h34);
    check("half_word_level", 32'(bus.oFIFO_LEVEL), 32'h0);
    put(8'h12);
    check("word1_data",   32'(bus.oDATA), 32'h1234);
    check("word1_dvalid", 32'(bus.oDATA_VALID), 32'h1);
    check("word1_level",  32'(bus.oFIFO_LEVEL), 32'h1);
    pulse_dack();
    check("pop_level", 32'(bus.oFIFO_LEVEL), 32'h0);
    pulse_dack();
    check("pop_empty_ignored", 32'(bus.oFIFO_LEVEL), 32'h0);

    // Escaped literal becomes data byte FE
    put(8'hFE); put(8'hFD); put(8'hAB);
    check("lit_data", 32'(bus.oDATA), 32'hABFE);
    check("lit_no_instr", 32'(bus.oINSTR_VALID), 32'h0);
    pulse_dack();

    // Fill the FIFO, back-pressure, then one pop admits more
    for (int i = 1; i <= 8; i++) put(8'(i));
    check("full_level", 32'(bus.oFIFO_LEVEL), 32'h4);
    check("full_ready", 32'(bus.oBYTE_READY), 32'h0);
    put(8'h09);
    check("blocked_level", 32'(bus.oFIFO_LEVEL), 32'h4);
    check("full_head", 32'(bus.oDATA), 32'h0201);
    pulse_dack();
    check("after_pop_level", 32'(bus.oFIFO_LEVEL), 32'h3);
    check("after_pop_ready", 32'(bus.oBYTE_READY), 32'h1);
    put(8'h09); put(8'h0A);
    check("refill_level", 32'(bus.oFIFO_LEVEL), 32'h4);
    check("head_w2", 32'(bus.oDATA), 32'h0403); pulse_dack();
    check("head_w3", 32'(bus.oDATA), 32'h0605); pulse_dack();
    check("head_w4", 32'(bus.oDATA), 32'h0807); pulse_dack();
    check("head_w5_wrap", 32'(bus.oDATA), 32'h0A09); pulse_dack();
    check("drained", 32'(bus.oDATA_VALID), 32'h0);

    // Escape-idle discards the partial byte
    put(8'h11); put(8'hFE); put(8'h00);
    check("idle_instr",  32'(bus.oINSTR), 32'h00);
    check("idle_ivalid", 32'(bus.oINSTR_VALID), 32'h1);
    check("idle_level",  32'(bus.oFIFO_LEVEL), 32'h0);
    pulse_iack();
    put(8'h22); put(8'h33);
    check("post_idle_word", 32'(bus.oDATA), 32'h3322);
    pulse_dack();

    // Escape error, post-with-ack, overflow, clear
    put(8'hFE); put(8'h55);
    check("err_instr", 32'(bus.oINSTR), 32'h7F);
    bus.iIDLE_TO_TAKE_COMMAND = 1'b1;
    put(8'h06, 1'b1);
    check("post_ack_instr",  32'(bus.oINSTR), 32'h06);
    check("post_ack_ivalid", 32'(bus.oINSTR_VALID), 32'h1);
    check("post_ack_no_ovf", 32'(bus.oOVERFLOW), 32'h0);
    put(8'h07);
    check("ovf_instr", 32'(bus.oINSTR), 32'h07);
    check("ovf_set",   32'(bus.oOVERFLOW), 32'h1);
    put(8'hFE); put(8'h01, 1'b0);
    check("esc_ack_instr", 32'(bus.oINSTR), 32'h7E);
    @(negedge iCLK); bus.iCLR_OVERFLOW = 1'b1;
    @(posedge iCLK); #1; bus.iCLR_OVERFLOW = 1'b0;
    check("ovf_cleared", 32'(bus.oOVERFLOW), 32'h0);
    pulse_iack();

    // Reset mid-word and mid-escape discards everything
    bus.iIDLE_TO_TAKE_COMMAND = 1'b0;
    put(8'h44); put(8'hFE);
    @(negedge iCLK); iRST_N = 1'b0;
    @(posedge iCLK); #1;
    check_reset_outputs("midrst");
    @(negedge iCLK); iRST_N = 1'b1;
    put(8'h66);
    check("fresh_half", 32'(bus.oFIFO_LEVEL), 32'h0);
    put(8'h55);
    check("fresh_word",   32'(bus.oDATA), 32'h5566);
    check("fresh_ivalid", 32'(bus.oINSTR_VALID), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
